// File: rtl/aes_input_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_loader_pkg
// Description : Shared definitions for the AES byte-serial input loader:
//               loader states, command byte field positions, reserved-bit
//               mask, block geometry and a command-rejection helper.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_loader_pkg;

  // Bytes per key block and per data block. Fixed by the AES datapath.
  localparam int BYTES_PER_BLOCK = 16;
  localparam int BLOCK_BITS      = BYTES_PER_BLOCK * 8;

  // Command byte layout
  localparam int         CMD_SEL_BIT   = 0;
  localparam int         CMD_REUSE_BIT = 1;
  // Bits that must always be zero. Bit1 is added to this set when key
  // reuse is compiled out (see aes_input_loader).
  localparam logic [7:0] CMD_RSVD_MASK = 8'hFC;

  // Byte counter value of the last byte of a block
  localparam logic [3:0] CNT_LAST = 4'(BYTES_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEY   = 3'd1,
    DATA  = 3'd2,
    START = 3'd3,
    BUSY  = 3'd4
  } state_t;

  // A command is rejected when any bit covered by the mask is set.
  function automatic logic cmd_rejected(input logic [7:0] cmd,
                                        input logic [7:0] mask);
    return |(cmd & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_input_loader_if.sv
`default_nettype none
// ============================================================================
// Interface   : aes_input_loader_if
// Description : Byte stream and AES core handoff signals of the input loader.
//               master : byte source / output side (drives in_byte, in_valid,
//                        done; observes everything else)
//               slave  : the loader itself
// Signals     : in_byte[7:0]  incoming byte
//               in_valid      in_byte valid this cycle
//               in_ready      loader accepts a byte this cycle
//               key[127:0]    assembled key, first byte in [127:120]
//               data[127:0]   assembled PT/CT block, first byte in [127:120]
//               sel           1 = encrypt, 0 = decrypt
//               start         one-cycle start pulse to the AES core
//               done          completion from the output side
//               err           one-cycle pulse on a rejected command byte
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_input_loader_if;

  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] data;
  logic         sel;
  logic         start;
  logic         done;
  logic         err;

  modport master (
    output in_byte, in_valid, done,
    input  in_ready, key, data, sel, start, err
  );

  modport slave (
    input  in_byte, in_valid, done,
    output in_ready, key, data, sel, start, err
  );

endinterface
`default_nettype wire

// File: rtl/aes_input_loader_block_shifter.sv
`default_nettype none
// ============================================================================
// Module      : block_shifter
// Description : Byte-wide shift register holding one AES block. Each enabled
//               cycle shifts the block left by one byte and appends din in
//               the low byte, so the first byte loaded ends up in the top
//               byte once a full block has been shifted in.
// Ports       : clk          system clock
//               clr          synchronous clear, active-high (wins over en)
//               en           shift enable
//               din[7:0]     byte to append
//               q[N*8-1:0]   block contents
// Revision    : 1.0 - initial release
// ============================================================================
module block_shifter
  import aes_loader_pkg::*;
#(
  parameter int NBYTES = BYTES_PER_BLOCK
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic [7:0]            din,
  output logic [NBYTES*8-1:0]   q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[NBYTES*8-9:0], din};
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : aes_input_loader
// Description : Byte-serial front end of the AES datapath. Accepts a framed
//               stream (command, 16 key bytes, 16 data bytes), assembles the
//               128-bit key and data words, registers the mode select and
//               issues a one-cycle start. The next frame is held off until
//               the output side signals done.
// Macro       : AES_KEY_REUSE_EN - when defined, command bit1 skips the key
//               phase and reuses the previously loaded key (17-byte frame).
//               When undefined, bit1 is a reserved bit and is rejected.
// Ports       : clk          system clock, rising edge
//               rst          synchronous reset, active-high
//               bus          aes_input_loader_if.slave (byte stream in,
//                            key/data/sel/start/err out, done in)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_input_loader
  import aes_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  aes_input_loader_if.slave   bus
);

`ifdef AES_KEY_REUSE_EN
  localparam logic [7:0] RSVD_MASK = CMD_RSVD_MASK;
`else
  localparam logic [7:0] RSVD_MASK = CMD_RSVD_MASK | (8'h01 << CMD_REUSE_BIT);
`endif

  state_t         state;
  logic [3:0]     byte_cnt;
  logic           sel_q;
  logic           start_q;
  logic           err_q;
  logic           accepting;
  logic           xfer;
  logic           key_shift;
  logic           data_shift;
  logic [127:0]   key_q;
  logic [127:0]   data_q;

  // Readiness depends on state only; reset gates it off combinationally so
  // no byte is taken while rst is held.
  assign accepting   = (state == IDLE) || (state == KEY) || (state == DATA);
  assign bus.in_ready = accepting && !rst;
  assign xfer        = bus.in_valid && bus.in_ready;

  assign key_shift   = xfer && (state == KEY);
  assign data_shift  = xfer && (state == DATA);

  // --------------------------------------------------------------------------
  // Control FSM with registered sel/start/err
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      sel_q    <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (cmd_rejected(bus.in_byte, RSVD_MASK)) begin
              err_q <= 1'b1;
            end else begin
              sel_q    <= bus.in_byte[CMD_SEL_BIT];
              byte_cnt <= '0;
`ifdef AES_KEY_REUSE_EN
              state    <= bus.in_byte[CMD_REUSE_BIT] ? DATA : KEY;
`else
              state    <= KEY;
`endif
            end
          end
        end

        KEY: begin
          if (xfer) begin
            // 4-bit counter wraps 15 -> 0 on its own, leaving it cleared
            // for the data phase.
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == CNT_LAST) begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == CNT_LAST) begin
              state   <= START;
              start_q <= 1'b1;
            end
          end
        end

        START: begin
          // done in this cycle is deliberately not looked at
          state <= BUSY;
        end

        BUSY: begin
          if (bus.done) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Key and data assembly
  // --------------------------------------------------------------------------
  block_shifter #(
    .NBYTES (BYTES_PER_BLOCK)
  ) u_key_shifter (
    .clk    (clk),
    .clr    (rst),
    .en     (key_shift),
    .din    (bus.in_byte),
    .q      (key_q)
  );

  block_shifter #(
    .NBYTES (BYTES_PER_BLOCK)
  ) u_data_shifter (
    .clk    (clk),
    .clr    (rst),
    .en     (data_shift),
    .din    (bus.in_byte),
    .q      (data_q)
  );

  assign bus.key   = key_q;
  assign bus.data  = data_q;
  assign bus.sel   = sel_q;
  assign bus.start = start_q;
  assign bus.err   = err_q;

endmodule
`default_nettype wire

// File: doc/aes_input_loader.md
# aes_input_loader

Byte-serial front end of the AES datapath. It receives a framed command stream (command byte, 16 key bytes, 16 data bytes) over a valid/ready byte interface, assembles 128-bit key and data words, drives the mode select, and issues a one-cycle start to the AES core. It is the input-side counterpart of the result selector: it holds off the next frame until the core/selector signal completion.

## Interface
- BYTES_PER_BLOCK, 16, bytes per key and per data block (fixed; not for override)
- Clk  in  1  system clock; all logic on rising edge
- Rst  in  1  synchronous reset, active-high
- InByte  in  8  incoming byte
- InValid  in  1  InByte valid this cycle
- InReady  out  1  loader accepts a byte this cycle; a byte transfers when InValid && InReady
- Key  out  128  assembled key; first key byte received lands in [127:120]
- Data  out  128  assembled PT/CT block; first data byte lands in [127:120]
- Sel  out  1  mode: 1 = encrypt (result taken from CT), 0 = decrypt (result from PT)
- Start  out  1  one-cycle pulse, Key/Data/Sel stable from this cycle until Done
- Done  in  1  completion from the output side (selector ready); sampled only in BUSY
- Err  out  1  one-cycle pulse on rejected command byte

## Operation
- Command byte: bit0 = Sel; bit1 = key-reuse flag (see Configuration); bits[7:2] reserved, must be 0.
- States: IDLE -> KEY -> DATA -> START -> BUSY -> IDLE.
- IDLE: InReady=1. Accepted byte with bits[7:2]!=0: dropped, Err pulses next cycle, stay IDLE. Valid command: Sel registered, counter cleared, go KEY (or DATA on key reuse).
- KEY: InReady=1. Each accepted byte shifts into Key: Key <= {Key[119:0], InByte}. After 16th byte, counter clears, go DATA.
- DATA: same shifting into Data. After 16th byte, go START.
- START: InReady=0; Start=1 for exactly this cycle; go BUSY.
- BUSY: InReady=0; stay until Done=1, then IDLE. Done outside BUSY is ignored.
- Byte counter: 4-bit, increments per accepted byte, wraps 15->0 at state change; no transfer when InValid=0 (gaps of any length allowed).
- Key, Data, Sel hold value in all states except during their own loading state; never cleared on Done.

## Timing
- Reset (Rst=1 at edge): state IDLE, counter 0, Key=0, Data=0, Sel=0, Start=0, Err=0. InReady=0 while Rst asserted (combinational gate), 1 on first cycle after.
- Reset mid-frame or in BUSY: frame discarded, return to IDLE; no Start issued.
- InReady is combinational from state only (not from InValid).
- Minimum frame latency: command accept cycle + 32 byte cycles -> Start asserted the cycle after the last data byte is accepted (1-cycle latency from final transfer).
- Done asserted in the same cycle Start is high: ignored (state is START, not BUSY).
- Done and InValid in BUSY same cycle: InReady=0, byte not taken; next frame starts the cycle after return to IDLE.

## Configuration
- AES_KEY_REUSE_EN defined: command bit1=1 skips KEY state; previously loaded Key reused; frame is 17 bytes.
- Not defined: bit1 is reserved; a command with bit1=1 is rejected like other reserved bits (Err pulse, stay IDLE).

## Structure
- Package aes_loader_pkg: state enum (IDLE, KEY, DATA, START, BUSY), CMD_SEL_BIT=0, CMD_REUSE_BIT=1, CMD_RSVD_MASK, BYTES_PER_BLOCK=16.
- One sub-module: block_shifter (128-bit byte-wide shift register with load enable and sync clear), instantiated twice for Key and Data.

## Test plan
- Reset then command 0x01, key bytes 0x00..0x0F, data 0x10..0x1F -> Start pulse one cycle after byte 33; Key=0x000102..0F, Data=0x1011..1F, Sel=1.
- Same frame with InValid toggling every other cycle -> identical Key/Data, Start delayed by gap count only.
- Command 0x84 -> Err pulse, no state change; following 0x00 frame loads normally with Sel=0.
- Done held high from START onward, then second frame offered during BUSY -> InReady=0 until Done sampled in BUSY, second frame accepted after.
- Rst asserted after 10th key byte -> all outputs return to reset values; next full frame loads correctly.
- AES_KEY_REUSE_EN: full frame then command 0x03 + 16 data bytes -> Key unchanged, Data updated, Start issued; without macro 0x03 -> Err.
